// File: rtl/iob_plic_claimer_pkg.sv
// Shared types and constants for the PLIC claim/complete sequencer.
// The FSM encoding and the spurious-ID rule live here so every user agrees on them.
package iob_plic_claimer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_CLAIM_REQ    = 3'd1,
    ST_CLAIM_WAIT   = 3'd2,
    ST_DELIVER      = 3'd3,
    ST_COMPLETE_REQ = 3'd4
  } claimer_state_t;

  // The PLIC returns ID 0 when nothing is pending at claim time.
  localparam int unsigned NO_IRQ_ID = 0;

  function automatic logic id_is_spurious(input int unsigned id, input int unsigned n_sources);
    return (id == NO_IRQ_ID) || (id > n_sources);
  endfunction

endpackage

// File: rtl/iob_plic_claimer_stats.sv
// Saturating claim / spurious-claim event counters for the PLIC claimer.
// Only instantiated when IOB_PLIC_CLAIMER_STATS_EN is defined.
module iob_plic_claimer_stats (
  input  logic        clk,
  input  logic        rst,
  input  logic        claim_inc,
  input  logic        spurious_inc,
  output logic [15:0] claim_cnt,
  output logic [15:0] spurious_cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      claim_cnt    <= '0;
      spurious_cnt <= '0;
    end else begin
      if (claim_inc && (claim_cnt != 16'hFFFF)) claim_cnt <= claim_cnt + 16'd1;
      if (spurious_inc && (spurious_cnt != 16'hFFFF)) spurious_cnt <= spurious_cnt + 16'd1;
    end
  end

endmodule

// File: rtl/iob_plic_claimer.sv
// Claims interrupts from a PLIC target over IOb, offers the ID to a consumer, then completes it.
// Optional event counters are built in with IOB_PLIC_CLAIMER_STATS_EN.
//
// state           | meaning
// ST_IDLE         | no transaction; samples meip_i
// ST_CLAIM_REQ    | claim read request held on IOb until accepted
// ST_CLAIM_WAIT   | waiting for claim read data (ID)
// ST_DELIVER      | ID offered to consumer until irq_ack_i
// ST_COMPLETE_REQ | complete write of ID held on IOb until accepted
module iob_plic_claimer
  import iob_plic_claimer_pkg::*;
#(
  parameter int                ADDR_W     = 16,
  parameter int                DATA_W     = 32,
  parameter int                N_SOURCES  = 8,
  parameter logic [ADDR_W-1:0] CLAIM_ADDR = 16'h2004,
  localparam int               ID_W       = $clog2(N_SOURCES + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                meip_i,
  output logic                iob_avalid_o,
  output logic [ADDR_W-1:0]   iob_addr_o,
  output logic [DATA_W-1:0]   iob_wdata_o,
  output logic [DATA_W/8-1:0] iob_wstrb_o,
  input  logic                iob_ready_i,
  input  logic                iob_rvalid_i,
  input  logic [DATA_W-1:0]   iob_rdata_i,
  output logic                irq_valid_o,
  output logic [ID_W-1:0]     irq_id_o,
  input  logic                irq_ack_i,
  output logic                busy_o
`ifdef IOB_PLIC_CLAIMER_STATS_EN
  ,
  output logic [15:0]         claim_cnt_o,
  output logic [15:0]         spurious_cnt_o
`endif
);

  claimer_state_t state_q, state_d;
  logic [ID_W-1:0] id_q;
  logic [ID_W-1:0] rd_id;
  logic            rd_spurious;
  logic            capture_valid;
  logic            unused_rdata_hi;

  assign rd_id           = iob_rdata_i[ID_W-1:0];
  assign rd_spurious     = id_is_spurious(32'(rd_id), N_SOURCES);
  assign unused_rdata_hi = ^iob_rdata_i[DATA_W-1:ID_W];

  // Read data is only looked at after acceptance, so a response in the acceptance cycle is ignored.
  assign capture_valid = (state_q == ST_CLAIM_WAIT) && iob_rvalid_i && !rd_spurious;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      if (capture_valid) id_q <= rd_id;
    end
  end

  always_comb begin
    state_d      = state_q;
    iob_avalid_o = 1'b0;
    iob_addr_o   = '0;
    iob_wdata_o  = '0;
    iob_wstrb_o  = '0;
    irq_valid_o  = 1'b0;
    irq_id_o     = '0;
    busy_o       = 1'b1;
    case (state_q)
      ST_IDLE: begin
        busy_o = 1'b0;
        if (meip_i) state_d = ST_CLAIM_REQ;
      end
      ST_CLAIM_REQ: begin
        iob_avalid_o = 1'b1;
        iob_addr_o   = CLAIM_ADDR;
        if (iob_ready_i) state_d = ST_CLAIM_WAIT;
      end
      ST_CLAIM_WAIT: begin
        if (iob_rvalid_i) state_d = rd_spurious ? ST_IDLE : ST_DELIVER;
      end
      ST_DELIVER: begin
        irq_valid_o = 1'b1;
        irq_id_o    = id_q;
        if (irq_ack_i) state_d = ST_COMPLETE_REQ;
      end
      ST_COMPLETE_REQ: begin
        iob_avalid_o = 1'b1;
        iob_addr_o   = CLAIM_ADDR;
        iob_wdata_o  = DATA_W'(id_q);
        iob_wstrb_o  = '1;
        if (iob_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef IOB_PLIC_CLAIMER_STATS_EN
  logic capture_spurious;
  assign capture_spurious = (state_q == ST_CLAIM_WAIT) && iob_rvalid_i && rd_spurious;

  iob_plic_claimer_stats u_stats (
    .clk          (clk_i),
    .rst          (rst_i),
    .claim_inc    (capture_valid),
    .spurious_inc (capture_spurious),
    .claim_cnt    (claim_cnt_o),
    .spurious_cnt (spurious_cnt_o)
  );
`endif

endmodule

// File: tb/tb_iob_plic_claimer.sv
// Directed self-checking bench for iob_plic_claimer (default parameters).
// Counter checks are compiled in when IOB_PLIC_CLAIMER_STATS_EN is defined.
module tb_iob_plic_claimer;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int ID_W   = 4;
  localparam logic [15:0] CADDR = 16'h2004;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              meip = 1'b0;
  logic              avalid;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [3:0]        wstrb;
  logic              ready = 1'b0;
  logic              rvalid = 1'b0;
  logic [DATA_W-1:0] rdata = '0;
  logic              irq_valid;
  logic [ID_W-1:0]   irq_id;
  logic              ack = 1'b0;
  logic              busy;
`ifdef IOB_PLIC_CLAIMER_STATS_EN
  logic [15:0]       claim_cnt;
  logic [15:0]       spurious_cnt;
`endif

  int checks = 0;
  int failures = 0;

  int               wr_cnt = 0;
  int               rd_cnt = 0;
  logic [DATA_W-1:0] wr_log[$];
  logic [ADDR_W-1:0] last_wr_addr = '0;

  always #5 clk = ~clk;

  iob_plic_claimer dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .meip_i       (meip),
    .iob_avalid_o (avalid),
    .iob_addr_o   (addr),
    .iob_wdata_o  (wdata),
    .iob_wstrb_o  (wstrb),
    .iob_ready_i  (ready),
    .iob_rvalid_i (rvalid),
    .iob_rdata_i  (rdata),
    .irq_valid_o  (irq_valid),
    .irq_id_o     (irq_id),
    .irq_ack_i    (ack),
    .busy_o       (busy)
`ifdef IOB_PLIC_CLAIMER_STATS_EN
    ,
    .claim_cnt_o    (claim_cnt),
    .spurious_cnt_o (spurious_cnt)
`endif
  );

  // Bus-side observer of accepted requests.
  always @(posedge clk) begin
    if (avalid && ready) begin
      if (wstrb != 4'h0) begin
        wr_cnt       <= wr_cnt + 1;
        last_wr_addr <= addr;
        wr_log.push_back(wdata);
      end else begin
        rd_cnt <= rd_cnt + 1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    checks++; if (avalid !== 1'b0) begin failures++; $display("FAIL reset_avalid got=%0b exp=0", avalid); end
    checks++; if (addr !== '0) begin failures++; $display("FAIL reset_addr got=%h exp=0", addr); end
    checks++; if ({wdata, wstrb} !== '0) begin failures++; $display("FAIL reset_wdata_wstrb got=%h/%h exp=0/0", wdata, wstrb); end
    checks++; if ({irq_valid, irq_id} !== '0) begin failures++; $display("FAIL reset_irq got=%b/%0d exp=0/0", irq_valid, irq_id); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
`ifdef IOB_PLIC_CLAIMER_STATS_EN
    checks++; if ({claim_cnt, spurious_cnt} !== 32'h0) begin failures++; $display("FAIL reset_stats got=%0d/%0d exp=0/0", claim_cnt, spurious_cnt); end
`endif
  endtask

  task automatic test_basic();
    int wr0;
    wr0 = wr_cnt;
    meip = 1'b1;
    step();
    meip = 1'b0;
    checks++; if ({avalid, addr, wstrb, wdata} !== {1'b1, CADDR, 4'h0, 32'h0}) begin failures++; $display("FAIL basic_claim_req got=%b/%h/%h/%h exp=1/2004/0/0", avalid, addr, wstrb, wdata); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy got=%0b exp=1", busy); end
    step();
    step();
    checks++; if ({avalid, addr} !== {1'b1, CADDR}) begin failures++; $display("FAIL basic_hold got=%b/%h exp=1/2004", avalid, addr); end
    ready = 1'b1;
    step();
    ready = 1'b0;
    checks++; if (avalid !== 1'b0) begin failures++; $display("FAIL basic_deassert got=%0b exp=0", avalid); end
    rvalid = 1'b1; rdata = 32'd5;
    step();
    rvalid = 1'b0; rdata = '0;
    step();
    checks++; if ({irq_valid, irq_id} !== {1'b1, 4'd5}) begin failures++; $display("FAIL basic_deliver got=%b/%0d exp=1/5", irq_valid, irq_id); end
    ack = 1'b1;
    step();
    ack = 1'b0;
    checks++; if ({avalid, addr, wdata, wstrb} !== {1'b1, CADDR, 32'd5, 4'hF}) begin failures++; $display("FAIL basic_complete got=%b/%h/%h/%h exp=1/2004/5/f", avalid, addr, wdata, wstrb); end
    checks++; if (irq_valid !== 1'b0) begin failures++; $display("FAIL basic_irq_drop got=%0b exp=0", irq_valid); end
    ready = 1'b1;
    step();
    ready = 1'b0;
    checks++; if ({busy, avalid} !== 2'b00) begin failures++; $display("FAIL basic_idle got=%b/%b exp=0/0", busy, avalid); end
    checks++; if ((wr_cnt - wr0) !== 1 || wr_log[$] !== 32'd5 || last_wr_addr !== CADDR) begin
      failures++; $display("FAIL basic_write_count got=%0d last=%0d addr=%h exp=1/5/2004", wr_cnt - wr0, wr_log[$], last_wr_addr);
    end
  endtask

  task automatic spurious_one(input logic [DATA_W-1:0] val);
    meip = 1'b1;
    step();
    meip = 1'b0;
    ready = 1'b1;
    step();
    ready = 1'b0;
    rvalid = 1'b1; rdata = val;
    step();
    rvalid = 1'b0; rdata = '0;
  endtask

  task automatic test_spurious();
    int wr0;
`ifdef IOB_PLIC_CLAIMER_STATS_EN
    logic [15:0] sp0, cl0;
    sp0 = spurious_cnt; cl0 = claim_cnt;
`endif
    wr0 = wr_cnt;
    spurious_one(32'd0);
    checks++; if ({busy, irq_valid, avalid} !== 3'b000) begin failures++; $display("FAIL spurious_zero got=%b%b%b exp=000", busy, irq_valid, avalid); end
    spurious_one(32'd9);
    checks++; if ({busy, irq_valid, avalid} !== 3'b000) begin failures++; $display("FAIL spurious_nine got=%b%b%b exp=000", busy, irq_valid, avalid); end
    step();
    step();
    checks++; if ((wr_cnt - wr0) !== 0 || busy !== 1'b0) begin failures++; $display("FAIL spurious_no_write got=%0d busy=%0b exp=0/0", wr_cnt - wr0, busy); end
`ifdef IOB_PLIC_CLAIMER_STATS_EN
    checks++; if ((spurious_cnt - sp0) !== 16'd2 || claim_cnt !== cl0) begin failures++; $display("FAIL spurious_cnt got=%0d claim_delta=%0d exp=2/0", spurious_cnt - sp0, claim_cnt - cl0); end
`endif
  endtask

  task automatic test_back_to_back();
    int wr0;
    int n;
    wr0 = wr_cnt;
    n = wr_log.size();
    meip = 1'b1;
    step();
    ready = 1'b1; step(); ready = 1'b0;
    rvalid = 1'b1; rdata = 32'd3; step(); rvalid = 1'b0; rdata = '0;
    checks++; if (irq_id !== 4'd3) begin failures++; $display("FAIL b2b_id3 got=%0d exp=3", irq_id); end
    ack = 1'b1; step(); ack = 1'b0;
    ready = 1'b1; step(); ready = 1'b0;
    checks++; if ({busy, avalid} !== 2'b00) begin failures++; $display("FAIL b2b_gap got=%b/%b exp=0/0", busy, avalid); end
    step();
    checks++; if ({busy, avalid, wstrb} !== {2'b11, 4'h0}) begin failures++; $display("FAIL b2b_second_claim got=%b/%b/%h exp=1/1/0", busy, avalid, wstrb); end
    ready = 1'b1; step(); ready = 1'b0;
    rvalid = 1'b1; rdata = 32'd7; step(); rvalid = 1'b0; rdata = '0;
    meip = 1'b0;
    checks++; if ({irq_valid, irq_id} !== {1'b1, 4'd7}) begin failures++; $display("FAIL b2b_id7 got=%b/%0d exp=1/7", irq_valid, irq_id); end
    ack = 1'b1; step(); ack = 1'b0;
    ready = 1'b1; step(); ready = 1'b0;
    checks++; if ((wr_cnt - wr0) !== 2 || wr_log[n] !== 32'd3 || wr_log[n+1] !== 32'd7) begin
      failures++; $display("FAIL b2b_writes got=%0d exp=2 (3,7)", wr_cnt - wr0);
    end
  endtask

  task automatic test_backpressure();
    int rd0;
    int bad;
    logic [ADDR_W+4:0] snap;
    rd0 = rd_cnt;
    bad = 0;
    meip = 1'b1;
    step();
    meip = 1'b0;
    snap = {avalid, addr, wstrb};
    for (int i = 0; i < 10; i++) begin
      if ({avalid, addr, wstrb} !== {1'b1, CADDR, 4'h0} || {avalid, addr, wstrb} !== snap) bad++;
      step();
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL bp_stable got=%0d unstable cycles exp=0", bad); end
    ready = 1'b1; rvalid = 1'b1; rdata = 32'd2;
    step();
    ready = 1'b0; rvalid = 1'b0; rdata = '0;
    checks++; if (avalid !== 1'b0 || (rd_cnt - rd0) !== 1) begin failures++; $display("FAIL bp_accept got avalid=%0b acc=%0d exp=0/1", avalid, rd_cnt - rd0); end
    step();
    checks++; if ({busy, irq_valid} !== 2'b10) begin failures++; $display("FAIL bp_accept_rvalid_ignored got=%b/%b exp=1/0", busy, irq_valid); end
    rvalid = 1'b1; rdata = 32'd6; step(); rvalid = 1'b0; rdata = '0;
    checks++; if ({irq_valid, irq_id} !== {1'b1, 4'd6}) begin failures++; $display("FAIL bp_deliver got=%b/%0d exp=1/6", irq_valid, irq_id); end
    ack = 1'b1; step(); ack = 1'b0;
    ready = 1'b1; step(); ready = 1'b0;
    checks++; if ((rd_cnt - rd0) !== 1 || busy !== 1'b0) begin failures++; $display("FAIL bp_one_accept got=%0d busy=%0b exp=1/0", rd_cnt - rd0, busy); end
  endtask

  task automatic test_reset_mid();
    int wr0;
    wr0 = wr_cnt;
    meip = 1'b1; step(); meip = 1'b0;
    ready = 1'b1; step(); ready = 1'b0;
    rst = 1'b1; step(); rst = 1'b0;
    checks++; if ({avalid, busy} !== 2'b00) begin failures++; $display("FAIL rstmid_abort got=%b/%b exp=0/0", avalid, busy); end
    rvalid = 1'b1; rdata = 32'd4; step(); rvalid = 1'b0; rdata = '0;
    checks++; if ({irq_valid, irq_id, busy} !== 6'b0) begin failures++; $display("FAIL rstmid_late_rvalid got=%b/%0d/%b exp=0/0/0", irq_valid, irq_id, busy); end
    step();
    checks++; if (avalid !== 1'b0 || (wr_cnt - wr0) !== 0) begin failures++; $display("FAIL rstmid_no_reissue got=%0b/%0d exp=0/0", avalid, wr_cnt - wr0); end
  endtask

  task automatic test_early_ack();
    int wr0;
    wr0 = wr_cnt;
    ack = 1'b1; step(); ack = 1'b0;
    checks++; if ({busy, avalid} !== 2'b00) begin failures++; $display("FAIL ack_idle got=%b/%b exp=0/0", busy, avalid); end
    meip = 1'b1; step(); meip = 1'b0;
    ready = 1'b1; step(); ready = 1'b0;
    ack = 1'b1; step(); ack = 1'b0;
    checks++; if ({busy, irq_valid, avalid} !== 3'b100) begin failures++; $display("FAIL ack_wait got=%b%b%b exp=100", busy, irq_valid, avalid); end
    rvalid = 1'b1; rdata = 32'd1; step(); rvalid = 1'b0; rdata = '0;
    step();
    checks++; if ({irq_valid, irq_id, avalid} !== {1'b1, 4'd1, 1'b0} || (wr_cnt - wr0) !== 0) begin
      failures++; $display("FAIL ack_still_delivering got=%b/%0d/%b writes=%0d exp=1/1/0/0", irq_valid, irq_id, avalid, wr_cnt - wr0);
    end
    ack = 1'b1; step(); ack = 1'b0;
    ready = 1'b1; step(); ready = 1'b0;
    checks++; if ((wr_cnt - wr0) !== 1 || wr_log[$] !== 32'd1) begin failures++; $display("FAIL ack_complete got=%0d last=%0d exp=1/1", wr_cnt - wr0, wr_log[$]); end
  endtask

  initial begin
    #2;
    test_reset();
    test_basic();
    test_spurious();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_early_ack();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/iob_plic_claimer.md
IOB_PLIC_CLAIMER -- requirements
Module: iob_plic_claimer

Interface
REQ-001 SHALL have parameter ADDR_W, default 16: IOb address width.
REQ-002 SHALL have parameter DATA_W, default 32: IOb data width.
REQ-003 SHALL have parameter N_SOURCES, default 8: number of interrupt sources; ID_W = clog2(N_SOURCES+1).
REQ-004 SHALL have parameter CLAIM_ADDR, default 16'h2004: claim/complete register address of the served target.
REQ-005 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-006 SHALL have port rst_i, input, 1 bit: synchronous active-high reset.
REQ-007 SHALL have port meip_i, input, 1 bit: target external interrupt line from the PLIC.
REQ-008 SHALL have IOb manager ports: iob_avalid_o (output, 1), iob_addr_o (output, ADDR_W), iob_wdata_o (output, DATA_W), iob_wstrb_o (output, DATA_W/8), iob_ready_i (input, 1), iob_rvalid_i (input, 1), iob_rdata_i (input, DATA_W).
REQ-009 SHALL have port irq_valid_o, output, 1 bit: a claimed interrupt ID is offered to the consumer.
REQ-010 SHALL have port irq_id_o, output, ID_W: the claimed ID, valid while irq_valid_o is high.
REQ-011 SHALL have port irq_ack_i, input, 1 bit: consumer finished servicing the interrupt.
REQ-012 SHALL have port busy_o, output, 1 bit: high in every state except IDLE.

Function
REQ-013 SHALL implement the FSM states IDLE, CLAIM_REQ, CLAIM_WAIT, DELIVER and COMPLETE_REQ.
REQ-014 SHALL move from IDLE to CLAIM_REQ on the edge where meip_i=1 is sampled in IDLE.
REQ-015 SHALL, in CLAIM_REQ, drive iob_avalid_o=1, iob_addr_o=CLAIM_ADDR and iob_wstrb_o=0, holding them stable until iob_ready_i=1 is sampled, then go to CLAIM_WAIT.
REQ-016 SHALL deassert iob_avalid_o in the cycle after acceptance (avalid&ready), never issuing back-to-back duplicate requests.
REQ-017 SHALL, in CLAIM_WAIT, ignore iob_rvalid_i in the acceptance cycle itself and, on the first later cycle with iob_rvalid_i=1, capture iob_rdata_i[ID_W-1:0].
REQ-018 SHALL treat a captured ID of 0 or an ID > N_SOURCES as spurious: it returns to IDLE with no complete write and no delivery.
REQ-019 SHALL, for a valid ID, go to DELIVER, where irq_valid_o=1 and irq_id_o=ID, held until irq_ack_i=1 is sampled.
REQ-020 SHALL ignore irq_ack_i in every state except DELIVER.
REQ-021 SHALL, in COMPLETE_REQ, drive iob_avalid_o=1, iob_addr_o=CLAIM_ADDR, iob_wdata_o=zero-extended ID and iob_wstrb_o=all ones, holding them until iob_ready_i=1, then return to IDLE; it does not wait for iob_rvalid_i.
REQ-022 SHALL spend at least one cycle in IDLE between transactions; if meip_i is still high, the next claim starts in the following cycle.
REQ-023 SHALL ignore meip_i changes outside IDLE; the pending state is re-evaluated only in IDLE.
REQ-024 SHALL drive iob_wdata_o=0 and iob_wstrb_o=0 whenever iob_avalid_o=0.

Reset
REQ-025 SHALL, when rst_i=1 at a clock edge, force state IDLE, iob_avalid_o=0, iob_addr_o=0, iob_wdata_o=0, iob_wstrb_o=0, irq_valid_o=0, irq_id_o=0 and busy_o=0 from the next cycle.
REQ-026 SHALL abort an in-flight request on reset mid-transaction, without re-issuing it, and discard any late iob_rvalid_i.

Configuration
REQ-027 SHALL, with IOB_PLIC_CLAIMER_STATS_EN defined, add outputs claim_cnt_o (16 bits) and spurious_cnt_o (16 bits).
REQ-028 SHALL, under IOB_PLIC_CLAIMER_STATS_EN, increment claim_cnt_o on each valid-ID capture and spurious_cnt_o on each spurious capture; both saturate at 16'hFFFF and reset to 0.
REQ-029 SHALL, without IOB_PLIC_CLAIMER_STATS_EN, omit the counter ports and logic, with all other behaviour identical.

Structure
REQ-030 SHALL place the FSM state encoding and the spurious-ID check constants in package iob_plic_claimer_pkg.
REQ-031 SHALL place the saturating counters in the single sub-module iob_plic_claimer_stats, instantiated only under IOB_PLIC_CLAIMER_STATS_EN.

Verification
REQ-032 SHALL cover the basic flow: meip_i=1, ready after 2 cycles, rvalid with rdata=5 -> irq_valid_o=1 with irq_id_o=5; irq_ack_i -> one write of wdata=5, wstrb=4'hF to CLAIM_ADDR.
REQ-033 SHALL cover a spurious ID: rdata=0, then rdata=9 with N_SOURCES=8 -> no delivery, no write, back to IDLE, spurious_cnt_o=2.
REQ-034 SHALL cover back-to-back interrupts: meip_i held high over two services with IDs 3 and 7 -> two claim/complete pairs separated by exactly one IDLE cycle.
REQ-035 SHALL cover ready back-pressure: iob_ready_i low for 10 cycles -> iob_avalid_o, iob_addr_o and iob_wstrb_o stable all 10 cycles, exactly one acceptance.
REQ-036 SHALL cover reset in CLAIM_WAIT: rst_i pulsed, then late rvalid with rdata=4 -> no delivery, iob_avalid_o=0, busy_o=0.
REQ-037 SHALL cover early ack: irq_ack_i pulsed in IDLE and CLAIM_WAIT -> ignored, no complete write issued.
